bubble_sort_controller: RTL and testbench
=========================================

Name: bubble_sort_controller

Overview:
- FSM sequencer that sorts an N-entry register file of k-bit words in place, in ascending unsigned order, using bubble sort.
- Drives the read selects of the register file's two read muxes and its single write port (select, enable, data).
- Arbitrates that write port between a host load/readback interface (while idle) and the sort engine (while busy).
- Sits between the top-level switch/key logic and the register file / seven-segment readout.

Parameters:
- k, 32, data word width.
- N, 4, number of register-file entries; N >= 2.
- AW, $clog2(N), address width; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  sort request; level-sampled, honoured only in IDLE.
- host_wr_en  in  1  host write request; honoured only in IDLE.
- host_addr  in  AW  host write/readback address.
- host_data  in  k  host write data.
- rd_data_a  in  k  register-file read port A data (combinational mux output).
- rd_data_b  in  k  register-file read port B data.
- rd_sel_a  out  AW  read port A select.
- rd_sel_b  out  AW  read port B select.
- wr_en  out  1  register-file write enable (feeds the write decoder enable).
- wr_sel  out  AW  write index.
- wr_data  out  k  write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse when sort completes.

Behaviour:
- States: IDLE, COMPARE, SWAP_LO, SWAP_HI, NEXT, DONE.
- Internal registers:
  - j: AW bits, current pair index.
  - pass: AW bits, pass counter.
  - swapped: 1 bit, set if any swap occurred in the current pass.
  - a_tmp, b_tmp: k bits each, latched operand pair.
- Reset (sampled at a clock edge with reset=1):
  - state=IDLE; j, pass, swapped, a_tmp, b_tmp all 0.
  - Outputs during and after reset: wr_en=0, wr_sel=0, wr_data=0, rd_sel_a=0, rd_sel_b=0, busy=0, done=0.
  - Reset mid-sort aborts immediately. Register-file contents are left partially sorted; the controller does not clear them.
- IDLE:
  - rd_sel_a=host_addr (readback); rd_sel_b=0.
  - wr_en=host_wr_en, wr_sel=host_addr, wr_data=host_data.
  - start=1: clear j, pass, swapped; go to COMPARE.
  - start and host_wr_en in the same cycle: the write commits on that edge, and the sort sees the new value.
- COMPARE:
  - rd_sel_a=j, rd_sel_b=j+1, wr_en=0.
  - Latch a_tmp<=rd_data_a, b_tmp<=rd_data_b.
  - If rd_data_a > rd_data_b (unsigned, k-bit): set swapped=1, go to SWAP_LO. Otherwise go to NEXT.
  - Equal values never swap (stable sort).
- SWAP_LO: wr_en=1, wr_sel=j, wr_data=b_tmp; go to SWAP_HI.
- SWAP_HI: wr_en=1, wr_sel=j+1, wr_data=a_tmp; go to NEXT.
- NEXT: wr_en=0.
  - If j == N-2-pass (end of pass):
    - If swapped==0 or pass==N-2: go to DONE.
    - Otherwise pass<=pass+1, j<=0, swapped<=0; go to COMPARE.
  - Otherwise j<=j+1; go to COMPARE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Host signals are ignored in every non-IDLE state. start held high after DONE launches a new sort from IDLE; re-sorting sorted data costs N-1 compare cycles plus NEXT cycles.
- Latency, counting cycles after the start-sampling edge until done=1:
  - Already sorted: 2(N-1)+1; for N=4 this is 7.
  - Reverse sorted, N=4: 25.
- All rd_sel, wr_* and done outputs are combinational from state and registers; they glitch-free-settle within the cycle.

Decomposition:
- Package bubble_sort_pkg:
  - typedef enum logic [2:0] sort_state_t for the six states.
  - Localparam for the state encodings.
- Sub-modules:
  - a_tmp and b_tmp use the existing parameterised register (k), with enable=COMPARE and reset tied to reset.
  - One natural new sub-module: bubble_sort_fsm, holding state, j, pass and swapped, and emitting select/enable strobes.
  - The top keeps the write-port arbitration muxes.

Test Plan:
- Reset, then host writes {3,1,2,0} to addresses 0..3 and start pulses -> busy=1 the next cycle; done pulses once; readback of addresses 0..3 = {0,1,2,3}.
- Preloaded {1,2,3,4}, start -> no cycle with wr_en=1; done in cycle 7; contents unchanged.
- Preloaded {4,3,2,1}, start -> exactly 12 wr_en cycles; done in cycle 25; result {1,2,3,4}.
- Duplicates {5,5,0,5} -> result {0,5,5,5}; no swap issued for equal pairs (wr_en count = 4).
- host_wr_en=1 addr 2 data 9 while busy -> no write from the host; result unaffected. The same write with start in IDLE -> 9 is included in the sort.
- reset=1 while in SWAP_LO -> the next cycle shows state IDLE, wr_en=0, busy=0, done=0, and no SWAP_HI write occurs.

Source files
------------

// File: rtl/bubble_sort_controller_pkg.sv
// Shared state encodings for the in-place bubble sort sequencer.
// The raw constants stay available for older code that compares against plain vectors.
package bubble_sort_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COMPARE = 3'd1;
   localparam logic [2:0] ST_SWAP_LO = 3'd2;
   localparam logic [2:0] ST_SWAP_HI = 3'd3;
   localparam logic [2:0] ST_NEXT    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      COMPARE = ST_COMPARE,
      SWAP_LO = ST_SWAP_LO,
      SWAP_HI = ST_SWAP_HI,
      NEXT    = ST_NEXT,
      DONE    = ST_DONE
   } sort_state_t;

endpackage

// File: rtl/bubble_sort_controller_if.sv
// Register-file side of the sorter: two combinational read ports and one write port.
interface bubble_sort_controller_if #(
   parameter int k  = 32,
   parameter int aw = 2
);

   logic [aw-1:0] rd_sel_a;
   logic [aw-1:0] rd_sel_b;
   logic [k-1:0]  rd_data_a;
   logic [k-1:0]  rd_data_b;
   logic          wr_en;
   logic [aw-1:0] wr_sel;
   logic [k-1:0]  wr_data;

   modport master (
      output rd_sel_a, rd_sel_b, wr_en, wr_sel, wr_data,
      input  rd_data_a, rd_data_b
   );

   modport slave (
      input  rd_sel_a, rd_sel_b, wr_en, wr_sel, wr_data,
      output rd_data_a, rd_data_b
   );

endinterface

// File: rtl/bubble_sort_fsm.sv
// Bubble sort sequencer: walks pair index j across shrinking passes and
// ends early once a pass completes without a swap.
module bubble_sort_fsm
   import bubble_sort_pkg::*;
#(
   parameter int k  = 32,
   parameter int N  = 4,
   parameter int AW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [k-1:0]  rdDataA,
   input  logic [k-1:0]  rdDataB,
   output logic [AW-1:0] j,
   output logic [AW-1:0] jPlus1,
   output logic          idle,
   output logic          compare,
   output logic          swapLo,
   output logic          swapHi,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] LAST_J = AW'(N - 2);

   sort_state_t   state;
   logic [AW-1:0] pass;
   logic          swapped;
   logic          endOfPass;

   assign endOfPass = (j == (LAST_J - pass));
   assign jPlus1    = j + AW'(1);

   // Sequencing: each compare either swaps (two write cycles) or goes straight to NEXT,
   // and NEXT decides between another pair, another pass, or finishing
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         j       <= '0;
         pass    <= '0;
         swapped <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  j       <= '0;
                  pass    <= '0;
                  swapped <= 1'b0;
                  state   <= COMPARE;
               end
            end
            COMPARE: begin
               if (rdDataA > rdDataB) begin
                  swapped <= 1'b1;
                  state   <= SWAP_LO;
               end else begin
                  state <= NEXT;
               end
            end
            SWAP_LO: state <= SWAP_HI;
            SWAP_HI: state <= NEXT;
            NEXT: begin
               if (endOfPass) begin
                  if (!swapped || pass == LAST_J) begin
                     state <= DONE;
                  end else begin
                     pass    <= pass + AW'(1);
                     j       <= '0;
                     swapped <= 1'b0;
                     state   <= COMPARE;
                  end
               end else begin
                  j     <= jPlus1;
                  state <= COMPARE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are masked while reset is held so nothing reaches the register file mid-abort
   always_comb begin
      idle    = !reset && (state == IDLE);
      compare = !reset && (state == COMPARE);
      swapLo  = !reset && (state == SWAP_LO);
      swapHi  = !reset && (state == SWAP_HI);
      busy    = !reset && (state != IDLE);
      done    = !reset && (state == DONE);
   end

endmodule

// File: rtl/data_register.sv
// Plain enabled register with synchronous active-high clear.
module DataRegister #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear wins over load so an aborted sort leaves no stale operand behind
   always_ff @(posedge clock) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/bubble_sort_controller.sv
// Sorts an N-entry register file in place and shares its write port with the
// host, which owns it only while the sorter is idle.
module bubble_sort_controller
   import bubble_sort_pkg::*;
#(
   parameter  int k  = 32,
   parameter  int N  = 4,
   localparam int AW = $clog2(N)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     host_wr_en,
   input  logic [AW-1:0]            host_addr,
   input  logic [k-1:0]             host_data,
   bubble_sort_controller_if.master rf,
   output logic                     busy,
   output logic                     done
);

   logic [AW-1:0] j;
   logic [AW-1:0] jPlus1;
   logic          idle;
   logic          compare;
   logic          swapLo;
   logic          swapHi;
   logic [k-1:0]  aTmp;
   logic [k-1:0]  bTmp;

   bubble_sort_fsm #(.k(k), .N(N), .AW(AW)) u_fsm (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .rdDataA (rf.rd_data_a),
      .rdDataB (rf.rd_data_b),
      .j       (j),
      .jPlus1  (jPlus1),
      .idle    (idle),
      .compare (compare),
      .swapLo  (swapLo),
      .swapHi  (swapHi),
      .busy    (busy),
      .done    (done)
   );

   DataRegister #(.W(k)) u_aTmp (
      .clock (clock),
      .reset (reset),
      .en    (compare),
      .d     (rf.rd_data_a),
      .q     (aTmp)
   );

   DataRegister #(.W(k)) u_bTmp (
      .clock (clock),
      .reset (reset),
      .en    (compare),
      .d     (rf.rd_data_b),
      .q     (bTmp)
   );

   // Port arbitration: the host path is live only in IDLE; a swap writes the latched
   // operands back crossed over, low slot first
   always_comb begin
      rf.rd_sel_a = '0;
      rf.rd_sel_b = '0;
      rf.wr_en    = 1'b0;
      rf.wr_sel   = '0;
      rf.wr_data  = '0;
      if (idle) begin
         rf.rd_sel_a = host_addr;
         rf.wr_en    = host_wr_en;
         rf.wr_sel   = host_addr;
         rf.wr_data  = host_data;
      end else if (compare) begin
         rf.rd_sel_a = j;
         rf.rd_sel_b = jPlus1;
      end else if (swapLo) begin
         rf.wr_en   = 1'b1;
         rf.wr_sel  = j;
         rf.wr_data = bTmp;
      end else if (swapHi) begin
         rf.wr_en   = 1'b1;
         rf.wr_sel  = jPlus1;
         rf.wr_data = aTmp;
      end
   end

endmodule

// File: tb/tb_bubble_sort_controller.sv
// Directed bench for bubble_sort_controller with a behavioural 4x32 register file.
module tb_bubble_sort_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        host_wr_en;
   logic [1:0]  host_addr;
   logic [31:0] host_data;
   logic        busy;
   logic        done;

   int testsRun  = 0;
   int failCount = 0;
   int wrCount   = 0;

   logic [31:0] mem [4];

   bubble_sort_controller_if #(.k(32), .aw(2)) rf ();

   bubble_sort_controller #(.k(32), .N(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .host_wr_en (host_wr_en),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .rf         (rf),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   // Register file model: combinational reads, write on the rising edge
   assign rf.rd_data_a = mem[rf.rd_sel_a];
   assign rf.rd_data_b = mem[rf.rd_sel_b];

   always @(posedge clock) begin
      if (rf.wr_en) begin
         mem[rf.wr_sel] <= rf.wr_data;
         wrCount++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic hostWrite(input logic [1:0] addr, input logic [31:0] data);
      @(negedge clock);
      host_wr_en = 1'b1;
      host_addr  = addr;
      host_data  = data;
      @(negedge clock);
      host_wr_en = 1'b0;
   endtask

   task automatic loadAll(input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3);
      hostWrite(2'd0, v0);
      hostWrite(2'd1, v1);
      hostWrite(2'd2, v2);
      hostWrite(2'd3, v3);
   endtask

   // Readback goes through the DUT's read-select path, not the model array
   task automatic checkContents(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] expv [4];
      expv = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         host_addr = 2'(i);
         #1 checkOutput($sformatf("%s rd%0d", tag, i), rf.rd_data_a, expv[i]);
      end
   endtask

   // Launch one sort and follow it to completion, counting cycles after the start edge
   task automatic applyStimulus(input string tag, input int expLatency, input int expWrites,
                                input bit hostNoise, input bit withWrite,
                                input logic [1:0] wAddr, input logic [31:0] wData);
      int cyc;
      int wrBase;
      wrBase = wrCount;
      @(negedge clock);
      start = 1'b1;
      if (withWrite) begin
         host_wr_en = 1'b1;
         host_addr  = wAddr;
         host_data  = wData;
      end
      @(negedge clock);
      start      = 1'b0;
      host_wr_en = hostNoise;
      if (hostNoise) begin
         host_addr = 2'd2;
         host_data = 32'd9;
      end
      cyc = 1;
      checkOutput({tag, " busy after start"}, busy, 1'b1);
      while (!done && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      checkOutput({tag, " done seen"}, done, 1'b1);
      checkOutput({tag, " latency"}, cyc, expLatency);
      checkOutput({tag, " write cycles"}, wrCount - wrBase, expWrites);
      host_wr_en = 1'b0;
      @(negedge clock);
      checkOutput({tag, " done single pulse"}, done, 1'b0);
      checkOutput({tag, " back to idle"}, busy, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      host_wr_en = 1'b1;
      host_addr  = 2'd3;
      host_data  = 32'd77;
      for (int i = 0; i < 4; i++) mem[i] = 32'd0;

      // Reset: every output forced low even with host signals active
      @(negedge clock);
      @(negedge clock);
      checkOutput("reset wr_en", rf.wr_en, 1'b0);
      checkOutput("reset wr_sel", rf.wr_sel, 2'd0);
      checkOutput("reset wr_data", rf.wr_data, 32'd0);
      checkOutput("reset rd_sel_a", rf.rd_sel_a, 2'd0);
      checkOutput("reset rd_sel_b", rf.rd_sel_b, 2'd0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset no host write", mem[3], 32'd0);
      host_wr_en = 1'b0;
      reset      = 1'b0;

      loadAll(32'd3, 32'd1, 32'd2, 32'd0);
      applyStimulus("mixed", 23, 10, 1'b0, 1'b0, 2'd0, 32'd0);
      checkContents("mixed", 32'd0, 32'd1, 32'd2, 32'd3);

      loadAll(32'd1, 32'd2, 32'd3, 32'd4);
      applyStimulus("sorted", 7, 0, 1'b0, 1'b0, 2'd0, 32'd0);
      checkContents("sorted", 32'd1, 32'd2, 32'd3, 32'd4);

      loadAll(32'd4, 32'd3, 32'd2, 32'd1);
      applyStimulus("reverse", 25, 12, 1'b0, 1'b0, 2'd0, 32'd0);
      checkContents("reverse", 32'd1, 32'd2, 32'd3, 32'd4);

      loadAll(32'd5, 32'd5, 32'd0, 32'd5);
      applyStimulus("dups", 17, 4, 1'b0, 1'b0, 2'd0, 32'd0);
      checkContents("dups", 32'd0, 32'd5, 32'd5, 32'd5);

      // Host write held high throughout a sort must be ignored
      loadAll(32'd4, 32'd3, 32'd2, 32'd1);
      applyStimulus("host busy", 25, 12, 1'b1, 1'b0, 2'd0, 32'd0);
      checkContents("host busy", 32'd1, 32'd2, 32'd3, 32'd4);

      // Host write coinciding with start lands first: {1,2,9,4} sorts to {1,2,4,9}
      applyStimulus("write+start", 13, 3, 1'b0, 1'b1, 2'd2, 32'd9);
      checkContents("write+start", 32'd1, 32'd2, 32'd4, 32'd9);

      // Abort in SWAP_LO: nothing written, controller back in IDLE
      loadAll(32'd2, 32'd1, 32'd3, 32'd4);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      checkOutput("swap_lo wr_en", rf.wr_en, 1'b1);
      checkOutput("swap_lo wr_sel", rf.wr_sel, 2'd0);
      checkOutput("swap_lo wr_data", rf.wr_data, 32'd1);
      reset = 1'b1;
      #1 checkOutput("abort wr_en during reset", rf.wr_en, 1'b0);
      @(negedge clock);
      checkOutput("abort busy", busy, 1'b0);
      checkOutput("abort done", done, 1'b0);
      checkOutput("abort wr_en", rf.wr_en, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("abort stays idle", busy, 1'b0);
      checkContents("abort", 32'd2, 32'd1, 32'd3, 32'd4);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
